// File: rtl/cache_lv2_pkg.sv
// Shared types and helpers for the LV2 write-back buffer.
package cache_lv2_pkg;

   localparam int unsigned ADDR_WID_LV2 = 32;
   localparam int unsigned DATA_WID_LV2 = 32;

   // Drain FSM state encoding
   typedef logic [0:0] wb_state_t;
   localparam wb_state_t WB_IDLE  = 1'b0;
   localparam wb_state_t WB_WRITE = 1'b1;

   // One buffer entry at the default LV2 widths
   typedef struct packed {
      logic                    valid;
      logic [ADDR_WID_LV2-1:0] addr;
      logic [DATA_WID_LV2-1:0] data;
   } wb_entry_t;

   // Pointer width for a given entry count; never narrower than one bit
   function automatic int unsigned ptr_wid(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/wb_match_lv2.sv
// Youngest-first address comparator over the circular buffer.
// Scans from head (oldest) to head+DEPTH-1 so the last match seen is the youngest.
module wb_match_lv2 #(
   parameter int unsigned ADDR_WID = 32,
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned PTR_WID  = 2
) (
   input  logic [DEPTH-1:0]               valid,
   input  logic [DEPTH-1:0][ADDR_WID-1:0] addrs,
   input  logic [PTR_WID-1:0]             head,
   input  logic                           skip_head,
   input  logic [ADDR_WID-1:0]            key,
   output logic                           hit,
   output logic [PTR_WID-1:0]             idx
);

   logic [PTR_WID-1:0] slot;

   // Walk entries in age order; later (younger) matches overwrite earlier ones
   always_comb begin
      hit  = 1'b0;
      idx  = head;
      slot = head;
      for (int k = 0; k < int'(DEPTH); k++) begin
         slot = head + PTR_WID'(k);
         if (valid[slot] && (addrs[slot] == key) && !(skip_head && (k == 0))) begin
            hit = 1'b1;
            idx = slot;
         end
      end
   end

endmodule

// File: rtl/cache_wb_buffer_lv2.sv
// Write-back buffer between the LV2 cache and main memory: queues dirty victims,
// coalesces same-address writes, forwards to LV2 read lookups and drains to memory.
module cache_wb_buffer_lv2
   import cache_lv2_pkg::*;
#(
   parameter int unsigned ADDR_WID     = ADDR_WID_LV2,
   parameter int unsigned DATA_WID     = DATA_WID_LV2,
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned PTR_WID      = ptr_wid(DEPTH),
   parameter int unsigned DRAIN_THRESH = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enq_valid,
   input  logic [ADDR_WID-1:0] enq_addr,
   input  logic [DATA_WID-1:0] enq_data,
   output logic                enq_ready,
   input  logic [ADDR_WID-1:0] lookup_addr,
   output logic                lookup_hit,
   output logic [DATA_WID-1:0] lookup_data,
   input  logic                mem_rd_pending,
   output logic [ADDR_WID-1:0] mem_addr,
   output logic [DATA_WID-1:0] mem_data,
   output logic                mem_wr,
   input  logic                mem_wr_done,
   input  logic                flush,
   output logic                flush_done,
   output logic [PTR_WID:0]    count,
   output logic                empty
);

   localparam logic [PTR_WID:0] DEPTH_C  = (PTR_WID + 1)'(DEPTH);
   localparam logic [PTR_WID:0] THRESH_C = (PTR_WID + 1)'(DRAIN_THRESH);

   logic [DEPTH-1:0]               valid_q;
   logic [DEPTH-1:0][ADDR_WID-1:0] addr_q;
   logic [DEPTH-1:0][DATA_WID-1:0] data_q;
   logic [PTR_WID-1:0]             head_q, tail_q;
   logic [PTR_WID:0]               count_q;
   wb_state_t                      state_q;
   logic [ADDR_WID-1:0]            mem_addr_q;
   logic [DATA_WID-1:0]            mem_data_q;

   logic               in_write, start, pop, enq_fire, enq_new;
   logic               coal_hit, look_hit;
   logic [PTR_WID-1:0] coal_idx, look_idx;
   logic [DATA_WID-1:0] head_data;

   // Coalesce target: the head is locked while it is being written to memory
   wb_match_lv2 #(
      .ADDR_WID (ADDR_WID),
      .DEPTH    (DEPTH),
      .PTR_WID  (PTR_WID)
   ) u_coal_match (
      .valid     (valid_q),
      .addrs     (addr_q),
      .head      (head_q),
      .skip_head (in_write),
      .key       (enq_addr),
      .hit       (coal_hit),
      .idx       (coal_idx)
   );

   // Read forwarding sees every valid entry, including an in-flight head
   wb_match_lv2 #(
      .ADDR_WID (ADDR_WID),
      .DEPTH    (DEPTH),
      .PTR_WID  (PTR_WID)
   ) u_look_match (
      .valid     (valid_q),
      .addrs     (addr_q),
      .head      (head_q),
      .skip_head (1'b0),
      .key       (lookup_addr),
      .hit       (look_hit),
      .idx       (look_idx)
   );

   // Handshake decode and head-data forwarding
   always_comb begin
      in_write  = (state_q == WB_WRITE);
      enq_ready = (count_q < DEPTH_C);
      enq_fire  = enq_valid && enq_ready;
      enq_new   = enq_fire && !coal_hit;
      pop       = in_write && mem_wr_done;
      start     = !in_write && (count_q != '0) &&
                  (flush || !mem_rd_pending || (count_q >= THRESH_C));
      // A coalesce into the head on the drain-start edge must reach memory
      head_data = data_q[head_q];
      if (enq_fire && coal_hit && (coal_idx == head_q)) begin
         head_data = enq_data;
      end
   end

   // Entry payloads need no reset; validity is tracked separately
   always_ff @(posedge clk) begin
      if (!rst && enq_fire) begin
         if (coal_hit) begin
            data_q[coal_idx] <= enq_data;
         end else begin
            addr_q[tail_q] <= enq_addr;
            data_q[tail_q] <= enq_data;
         end
      end
   end

   // Validity, pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (pop) begin
            valid_q[head_q] <= 1'b0;
            head_q          <= head_q + 1'b1;
         end
         if (enq_new) begin
            valid_q[tail_q] <= 1'b1;
            tail_q          <= tail_q + 1'b1;
         end
         case ({enq_new, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Drain FSM: latch head on entry to WRITE, release on mem_wr_done
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= WB_IDLE;
         mem_addr_q <= '0;
         mem_data_q <= '0;
      end else if (start) begin
         state_q    <= WB_WRITE;
         mem_addr_q <= addr_q[head_q];
         mem_data_q <= head_data;
      end else if (pop) begin
         state_q <= WB_IDLE;
      end
   end

   // Output mapping
   always_comb begin
      mem_wr      = in_write;
      mem_addr    = mem_addr_q;
      mem_data    = mem_data_q;
      count       = count_q;
      empty       = (count_q == '0);
      flush_done  = flush && (count_q == '0) && !in_write;
      lookup_hit  = look_hit;
      lookup_data = look_hit ? data_q[look_idx] : '0;
   end

endmodule

// File: tb/tb_cache_wb_buffer_lv2.sv
// Randomised bench for cache_wb_buffer_lv2 against a queue-based reference model.
module tb_cache_wb_buffer_lv2;

   localparam int unsigned AW     = 32;
   localparam int unsigned DW     = 32;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned PW     = 2;
   localparam int unsigned THRESH = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          enq_valid;
   logic [AW-1:0] enq_addr;
   logic [DW-1:0] enq_data;
   logic          enq_ready;
   logic [AW-1:0] lookup_addr;
   logic          lookup_hit;
   logic [DW-1:0] lookup_data;
   logic          mem_rd_pending;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data;
   logic          mem_wr;
   logic          mem_wr_done;
   logic          flush;
   logic          flush_done;
   logic [PW:0]   count;
   logic          empty;

   always #5 clk = ~clk;

   cache_wb_buffer_lv2 #(
      .ADDR_WID     (AW),
      .DATA_WID     (DW),
      .DEPTH        (DEPTH),
      .PTR_WID      (PW),
      .DRAIN_THRESH (THRESH)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .enq_valid      (enq_valid),
      .enq_addr       (enq_addr),
      .enq_data       (enq_data),
      .enq_ready      (enq_ready),
      .lookup_addr    (lookup_addr),
      .lookup_hit     (lookup_hit),
      .lookup_data    (lookup_data),
      .mem_rd_pending (mem_rd_pending),
      .mem_addr       (mem_addr),
      .mem_data       (mem_data),
      .mem_wr         (mem_wr),
      .mem_wr_done    (mem_wr_done),
      .flush          (flush),
      .flush_done     (flush_done),
      .count          (count),
      .empty          (empty)
   );

   // Reference model: FIFO of pending writes plus the write currently offered to memory
   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } ent_t;

   ent_t          mq[$];
   bit            m_busy;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;
   int            n_vec = 0;
   int            n_err = 0;
   int            n_wr  = 0;
   int            dly   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [AW-1:0] rnd_addr();
      return 32'h100 + 32'(4 * $urandom_range(0, 5));
   endfunction

   // Memory model: completes a write 1..5 cycles after it is offered, stray pulses when idle
   function automatic bit next_done();
      if (m_busy) begin
         if (dly == 0) dly = $urandom_range(1, 5);
         dly--;
         return (dly == 0);
      end
      return ($urandom_range(0, 9) == 0);
   endfunction

   task automatic step(input bit ev, input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                       input logic [AW-1:0] la, input bit rp, input bit dn, input bit fl,
                       input bit r);
      bit            hit;
      logic [DW-1:0] ld;
      int            pre;
      int            j;
      bit            pop;
      bit            start;
      ent_t          e;
      @(negedge clk);
      enq_valid      = ev;
      enq_addr       = ea;
      enq_data       = ed;
      lookup_addr    = la;
      mem_rd_pending = rp;
      mem_wr_done    = dn;
      flush          = fl;
      rst            = r;
      #1;
      hit = 1'b0;
      ld  = '0;
      foreach (mq[i]) if (mq[i].addr == la) begin
         hit = 1'b1;
         ld  = mq[i].data;
      end
      chk("count", 64'(count), 64'(mq.size()));
      chk("empty", 64'(empty), 64'(mq.size() == 0));
      chk("enq_ready", 64'(enq_ready), 64'(mq.size() < DEPTH));
      chk("mem_wr", 64'(mem_wr), 64'(m_busy));
      chk("mem_addr", 64'(mem_addr), 64'(m_addr));
      chk("mem_data", 64'(mem_data), 64'(m_data));
      chk("lookup_hit", 64'(lookup_hit), 64'(hit));
      chk("lookup_data", 64'(lookup_data), 64'(ld));
      chk("flush_done", 64'(flush_done), 64'(fl && (mq.size() == 0) && !m_busy));
      @(posedge clk);
      if (r) begin
         mq.delete();
         m_busy = 1'b0;
         m_addr = '0;
         m_data = '0;
         dly    = 0;
      end else begin
         pre   = mq.size();
         pop   = m_busy && dn;
         start = !m_busy && (pre > 0) && (fl || !rp || (pre >= THRESH));
         if (ev && (pre < DEPTH)) begin
            j = -1;
            for (int i = pre - 1; i >= (m_busy ? 1 : 0); i--) begin
               if (mq[i].addr == ea) begin
                  j = i;
                  break;
               end
            end
            if (j >= 0) begin
               e      = mq[j];
               e.data = ed;
               mq[j]  = e;
            end else begin
               e.addr = ea;
               e.data = ed;
               mq.push_back(e);
            end
         end
         if (pop) begin
            void'(mq.pop_front());
            m_busy = 1'b0;
            n_wr++;
         end
         if (start) begin
            m_busy = 1'b1;
            m_addr = mq[0].addr;
            m_data = mq[0].data;
         end
      end
   endtask

   task automatic enq(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit rp);
      step(1'b1, a, d, a, rp, next_done(), 1'b0, 1'b0);
   endtask

   task automatic run(input int n, input bit rp, input bit fl, input logic [AW-1:0] la);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, la, rp, next_done(), fl, 1'b0);
   endtask

   initial begin
      rst            = 1'b1;
      enq_valid      = 1'b0;
      enq_addr       = '0;
      enq_data       = '0;
      lookup_addr    = '0;
      mem_rd_pending = 1'b0;
      mem_wr_done    = 1'b0;
      flush          = 1'b0;
      repeat (2) @(posedge clk);
      mq.delete();
      m_busy = 1'b0;
      m_addr = '0;
      m_data = '0;

      // Basic drain
      enq(32'h100, 32'h11, 1'b0);
      run(8, 1'b0, 1'b0, 32'h100);

      // Coalesce while a memory read holds off draining
      enq(32'h200, 32'hAA, 1'b1);
      enq(32'h200, 32'hBB, 1'b1);
      run(2, 1'b1, 1'b0, 32'h200);
      run(8, 1'b0, 1'b0, 32'h200);

      // Threshold override
      enq(32'h10, 32'h1, 1'b1);
      enq(32'h14, 32'h2, 1'b1);
      enq(32'h18, 32'h3, 1'b1);
      run(3, 1'b1, 1'b0, 32'h14);
      run(15, 1'b0, 1'b0, 32'h18);

      // Full buffer refuses further writes, including same-address ones
      for (int i = 0; i < 4; i++) enq(32'h40 + 32'(4 * i), 32'(i + 1), 1'b1);
      step(1'b1, 32'h50, 32'h99, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h44, 32'h99, 32'h44, 1'b1, 1'b0, 1'b0, 1'b0);
      run(30, 1'b0, 1'b0, 32'h44);

      // In-flight head is locked; a same-address write allocates and wins the lookup
      step(1'b1, 32'h300, 32'h1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, '0, '0, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h300, 32'h2, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, '0, '0, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0);
      dly = 0;
      run(15, 1'b0, 1'b0, 32'h300);

      // Reset during a write, then flush against a pending read
      enq(32'h60, 32'h6, 1'b1);
      enq(32'h64, 32'h7, 1'b1);
      step(1'b1, 32'h68, 32'h8, 32'h60, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, '0, '0, 32'h60, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, '0, '0, 32'h60, 1'b1, 1'b0, 1'b0, 1'b1);
      dly = 0;
      enq(32'h70, 32'hA, 1'b1);
      enq(32'h74, 32'hB, 1'b1);
      run(20, 1'b1, 1'b1, 32'h74);

      // Random traffic
      for (int c = 0; c < 4000; c++) begin
         step($urandom_range(0, 2) != 0, rnd_addr(), $urandom(), rnd_addr(),
              $urandom_range(0, 2) != 0, next_done(), $urandom_range(0, 15) == 0,
              $urandom_range(0, 299) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
